// File: rtl/digest_unloader_64.sv
// Captures a finished digest on a load pulse and streams it out as DATA_W-bit
// words, most significant word first, over a valid/ready handshake.
module digest_unloader_64 #(
   parameter int DATA_W   = 64,
   parameter int DIGEST_W = 256
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                load,
   input  logic [DIGEST_W-1:0] digest_i,
   input  logic                ready_i,
   output logic [DATA_W-1:0]   data_o,
   output logic                valid_o,
   output logic                last_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam int NUM_WORDS = DIGEST_W / DATA_W;
   localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_r, state_n_s;
   logic [DIGEST_W-1:0] shift_r, shift_n_s;
   logic [CNT_W-1:0]    cnt_r, cnt_n_s;
   logic                valid_r, valid_n_s;
   logic                last_r, last_n_s;
   logic                busy_r, busy_n_s;
   logic                done_r, done_n_s;

   // State and output registers; the shift register is zeroed whenever idle so data_o reads 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= IDLE;
         shift_r <= {DIGEST_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_n_s;
         shift_r <= shift_n_s;
         cnt_r   <= cnt_n_s;
         valid_r <= valid_n_s;
         last_r  <= last_n_s;
         busy_r  <= busy_n_s;
         done_r  <= done_n_s;
      end
   end

   // Next-state logic: capture on load when idle, advance one word per handshake.
   always_comb begin
      state_n_s = state_r;
      shift_n_s = shift_r;
      cnt_n_s   = cnt_r;
      valid_n_s = valid_r;
      last_n_s  = last_r;
      busy_n_s  = busy_r;
      done_n_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (load) begin
               state_n_s = SEND;
               shift_n_s = digest_i;
               cnt_n_s   = {CNT_W{1'b0}};
               valid_n_s = 1'b1;
               last_n_s  = (LAST_CNT == {CNT_W{1'b0}});
               busy_n_s  = 1'b1;
            end else begin
               state_n_s = IDLE;
            end
         end
         SEND: begin
            if (ready_i) begin
               if (cnt_r == LAST_CNT) begin
                  state_n_s = IDLE;
                  shift_n_s = {DIGEST_W{1'b0}};
                  cnt_n_s   = {CNT_W{1'b0}};
                  valid_n_s = 1'b0;
                  last_n_s  = 1'b0;
                  busy_n_s  = 1'b0;
                  done_n_s  = 1'b1;
               end else begin
                  shift_n_s = shift_r << DATA_W;
                  cnt_n_s   = cnt_r + 1'b1;
                  last_n_s  = ((cnt_r + 1'b1) == LAST_CNT);
               end
            end else begin
               state_n_s = SEND;
            end
         end
         default: begin
            state_n_s = IDLE;
            shift_n_s = {DIGEST_W{1'b0}};
            cnt_n_s   = {CNT_W{1'b0}};
            valid_n_s = 1'b0;
            last_n_s  = 1'b0;
            busy_n_s  = 1'b0;
         end
      endcase
   end

   assign data_o  = shift_r[DIGEST_W-1 -: DATA_W];
   assign valid_o = valid_r;
   assign last_o  = last_r;
   assign busy_o  = busy_r;
   assign done_o  = done_r;

endmodule

// File: doc/digest_unloader_64.md
Name: digest_unloader_64

Overview:
Output-side counterpart to the 64-bit load registers in the SHA-256 core. Captures the finished 256-bit digest in one cycle on a load pulse, then streams it out as 64-bit words over a valid/ready handshake, most significant word first. Sits between the hash core's H0..H7 state and the downstream host/bus interface. Signals completion with a one-cycle done pulse.

Parameters:
DATA_W, 64, output word width in bits
DIGEST_W, 256, digest width in bits; must be an integer multiple of DATA_W
NUM_WORDS, DIGEST_W/DATA_W (=4), derived localparam; number of beats per digest

Ports:
CLK  input  1  clock; all logic on the rising edge
RST  input  1  reset; synchronous, active-high
load  input  1  capture digest_i; honoured only when busy_o=0
digest_i  input  DIGEST_W  digest {H0,...,H7}; H0 in bits [255:224]
ready_i  input  1  downstream accepts data_o this cycle
data_o  output  DATA_W  current output word
valid_o  output  1  data_o valid
last_o  output  1  high with valid_o on the final word only
busy_o  output  1  transfer in progress (digest held)
done_o  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset (RST=1 at a rising edge): state IDLE; data_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0; shift register and beat counter cleared. Dominates every other input.
- States: IDLE, SEND.
- IDLE: valid_o=0, busy_o=0. On load=1: capture digest_i into the shift register, set beat count=0, go to SEND. Next cycle: valid_o=1, data_o=digest_i[DIGEST_W-1 -: DATA_W]. Load-to-first-valid latency is 1 cycle.
- SEND: valid_o=1, busy_o=1. Handshake occurs when valid_o & ready_i.
  - On a handshake that is not the last beat: shift the register left by DATA_W, increment the count, and present the next word the following cycle. Sustained ready_i gives 1 word/cycle.
  - With no handshake: data_o, last_o and the count hold stable. valid_o never deasserts once raised until its word is accepted.
  - last_o=1 exactly when count==NUM_WORDS-1 and valid_o=1.
  - On the handshake of the last beat: next cycle valid_o=0, last_o=0, busy_o=0, done_o=1 for one cycle, state IDLE, data_o=0.
- load while busy_o=1 (including the final-handshake cycle) is ignored. The held digest is unaffected.
- load in the cycle done_o=1 is accepted, because the state is already IDLE. The new first word is valid the next cycle.
- ready_i while valid_o=0 has no effect.
- Word order is big-endian: word k = digest_i[DIGEST_W-1-k*DATA_W -: DATA_W].
- RST mid-transfer aborts the transfer. No done_o is generated and the remaining words are discarded.
- Count width is clog2(NUM_WORDS). It never wraps past NUM_WORDS-1.

Test Plan:
1. Reset then load with digest_i = SHA-256("abc") = ba7816bf...f20015ad and ready_i=1 -> cycles 1-4 show data_o = ba7816bf8f01cfea, 414140de5dae2223, b00361a396177a9c, b410ff61f20015ad; last_o only on beat 4; done_o=1 on cycle 5.
2. Same digest with ready_i toggling 0/1 every cycle -> each word held stable while ready_i=0; same 4-word order; done_o one cycle after the 4th accept; total 8 cycles.
3. Second load (all-ones digest) pulsed during beat 2 -> ignored; output remains the "abc" words; busy_o stays 1 until completion.
4. Load issued in the done_o cycle with digest_i = 0x0123...cdef pattern -> first word 0123456789abcdef valid the next cycle; no idle gap beyond 1 cycle.
5. RST asserted while valid_o=1 at beat 3 -> next cycle all outputs 0, done_o never pulses; a subsequent load restarts from word 0.
6. ready_i held 1 in IDLE with no load -> valid_o, busy_o, done_o remain 0 indefinitely.
